// File: rtl/riscv_mc_control.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/writeback over a shared memory.
// Optional performance counters are built when RISCV_MC_PERF_EN is defined.
module riscv_mc_control #(
   parameter int unsigned ALUCTRL_W  = 3,
   parameter int unsigned TMO_W      = 4,
   parameter int unsigned TMO_CYCLES = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [6:0]           op,
   input  logic [2:0]           func3,
   input  logic                 func7_5,
   input  logic                 zero,
   input  logic                 mem_ready,
   output logic                 mem_req,
   output logic                 MemWrite,
   output logic                 AdrSrc,
   output logic                 IRWrite,
   output logic                 PCWrite,
   output logic                 RegWrite,
   output logic [1:0]           ALUSrcA,
   output logic [1:0]           ALUSrcB,
   output logic [1:0]           ImmSrc,
   output logic [1:0]           ResultSrc,
   output logic [ALUCTRL_W-1:0] ALUControl,
   output logic                 fault
`ifdef RISCV_MC_PERF_EN
   ,
   output logic [31:0]          cycle_cnt,
   output logic [31:0]          instret_cnt
`endif
);

   localparam logic [ALUCTRL_W-1:0] AluAdd = ALUCTRL_W'(3'b000);
   localparam logic [ALUCTRL_W-1:0] AluSub = ALUCTRL_W'(3'b001);
   localparam logic [ALUCTRL_W-1:0] AluAnd = ALUCTRL_W'(3'b010);
   localparam logic [ALUCTRL_W-1:0] AluOr  = ALUCTRL_W'(3'b011);
   localparam logic [ALUCTRL_W-1:0] AluSlt = ALUCTRL_W'(3'b101);

   localparam logic [TMO_W-1:0] TmoLast = TMO_W'(TMO_CYCLES - 1);

   localparam logic [6:0] OpLoad  = 7'b0000011;
   localparam logic [6:0] OpStore = 7'b0100011;
   localparam logic [6:0] OpRtype = 7'b0110011;
   localparam logic [6:0] OpItype = 7'b0010011;
   localparam logic [6:0] OpBeq   = 7'b1100011;
   localparam logic [6:0] OpJal   = 7'b1101111;

   typedef enum logic [3:0] {
      StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr,
      StExecR, StExecI, StAluWb, StBeq, StJal, StFault
   } state_e;

   state_e               state_q, state_d;
   logic [TMO_W-1:0]     wait_q, wait_d;
   logic [ALUCTRL_W-1:0] alu_dec;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StFetch;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   // Next state; a mem_ready on the final tolerated cycle beats the timeout
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StFetch: begin
            if (mem_ready)              state_d = StDecode;
            else if (wait_q == TmoLast) state_d = StFault;
         end
         StDecode: begin
            case (op)
               OpLoad, OpStore: state_d = StMemAdr;
               OpRtype:         state_d = StExecR;
               OpItype:         state_d = StExecI;
               OpBeq:           state_d = StBeq;
               OpJal:           state_d = StJal;
               default:         state_d = StFault;
            endcase
         end
         StMemAdr: state_d = (op == OpStore) ? StMemWr : StMemRd;
         StMemRd: begin
            if (mem_ready)              state_d = StMemWb;
            else if (wait_q == TmoLast) state_d = StFault;
         end
         StMemWr: begin
            if (mem_ready)              state_d = StFetch;
            else if (wait_q == TmoLast) state_d = StFault;
         end
         StExecR, StExecI: state_d = StAluWb;
         StMemWb, StAluWb, StBeq, StJal: state_d = StFetch;
         StFault: state_d = StFault;
         default: state_d = StFault;
      endcase
   end

   // Wait counter restarts on every state change, so entering a memory state clears it
   always_comb begin
      wait_d = wait_q;
      if (state_d != state_q) begin
         wait_d = '0;
      end else if (mem_req && !mem_ready) begin
         wait_d = wait_q + TMO_W'(1);
      end
   end

   always_comb begin
      alu_dec = AluAdd;
      case (func3)
         3'b000:  if (state_q == StExecR && func7_5) alu_dec = AluSub;
         3'b010:  alu_dec = AluSlt;
         3'b110:  alu_dec = AluOr;
         3'b111:  alu_dec = AluAnd;
         default: alu_dec = AluAdd;
      endcase
   end

   // Outputs; all strobes and mem_req are forced low while rst is asserted
   always_comb begin
      mem_req    = 1'b0;
      MemWrite   = 1'b0;
      AdrSrc     = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ImmSrc     = 2'b00;
      ResultSrc  = 2'b00;
      ALUControl = AluAdd;
      fault      = 1'b0;
      if (!rst) begin
         unique case (state_q)
            StFetch: begin
               mem_req   = 1'b1;
               ALUSrcB   = 2'b10;
               ResultSrc = 2'b10;
               IRWrite   = mem_ready;
               PCWrite   = mem_ready;
            end
            StDecode: begin
               ALUSrcA = 2'b01;
               ALUSrcB = 2'b01;
               ImmSrc  = 2'b10;
            end
            StMemAdr: begin
               ALUSrcA = 2'b10;
               ALUSrcB = 2'b01;
               ImmSrc  = (op == OpStore) ? 2'b01 : 2'b00;
            end
            StMemRd: begin
               mem_req = 1'b1;
               AdrSrc  = 1'b1;
            end
            StMemWb: begin
               ResultSrc = 2'b01;
               RegWrite  = 1'b1;
            end
            StMemWr: begin
               mem_req  = 1'b1;
               MemWrite = 1'b1;
               AdrSrc   = 1'b1;
            end
            StExecR: begin
               ALUSrcA    = 2'b10;
               ALUControl = alu_dec;
            end
            StExecI: begin
               ALUSrcA    = 2'b10;
               ALUSrcB    = 2'b01;
               ALUControl = alu_dec;
            end
            StAluWb: RegWrite = 1'b1;
            StBeq: begin
               ALUSrcA    = 2'b10;
               ALUControl = AluSub;
               PCWrite    = zero;
            end
            StJal: begin
               ALUSrcA  = 2'b01;
               ALUSrcB  = 2'b10;
               RegWrite = 1'b1;
               PCWrite  = 1'b1;
            end
            StFault: fault = 1'b1;
            default: fault = 1'b1;
         endcase
      end
   end

`ifdef RISCV_MC_PERF_EN
   logic retire;
   assign retire = (state_d == StFetch) &&
                   (state_q inside {StMemWb, StMemWr, StAluWb, StBeq, StJal});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         if (state_q != StFault) cycle_cnt <= cycle_cnt + 32'd1;
         if (retire) instret_cnt <= instret_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_riscv_mc_control.sv
// Self-checking bench for riscv_mc_control: per-cycle expected control vectors via a scoreboard queue.
// Counter checks are compiled only when RISCV_MC_PERF_EN is defined.
module tb_riscv_mc_control;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] op = 7'b0110011;
   logic [2:0] func3 = 3'b000;
   logic       func7_5 = 1'b0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, fault;
   logic [1:0] ALUSrcA, ALUSrcB, ImmSrc, ResultSrc;
   logic [2:0] ALUControl;
`ifdef RISCV_MC_PERF_EN
   logic [31:0] cycle_cnt, instret_cnt;
`endif

   riscv_mc_control dut (
      .clk(clk), .rst(rst), .op(op), .func3(func3), .func7_5(func7_5), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
      .fault(fault)
`ifdef RISCV_MC_PERF_EN
      , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       req, mw, adr, irw, pcw, rw;
      logic [1:0] srca, srcb, imm, res;
      logic [2:0] alu;
      logic       flt;
   } obs_t;

   typedef struct {
      logic rdy;
      logic z;
      obs_t e;
   } step_t;

   obs_t obs;
   assign obs = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                 ALUSrcA, ALUSrcB, ImmSrc, ResultSrc, ALUControl, fault};

   obs_t sb_q[$];
   int   tests_run = 0;
   int   tests_failed = 0;

   function automatic obs_t mk(logic req, logic mw, logic adr, logic irw, logic pcw, logic rw,
                               logic [1:0] a, logic [1:0] b, logic [1:0] imm, logic [1:0] res,
                               logic [2:0] alu, logic f);
      obs_t o;
      o = {req, mw, adr, irw, pcw, rw, a, b, imm, res, alu, f};
      return o;
   endfunction

   function automatic obs_t e_fetch(logic r);
      return mk(1, 0, 0, r, r, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b000, 0);
   endfunction
   function automatic obs_t e_decode();
      return mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b10, 2'b00, 3'b000, 0);
   endfunction
   function automatic obs_t e_memadr(logic st);
      return mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, {1'b0, st}, 2'b00, 3'b000, 0);
   endfunction
   function automatic obs_t e_memrd();
      return mk(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
   endfunction
   function automatic obs_t e_memwb();
      return mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0);
   endfunction
   function automatic obs_t e_memwr();
      return mk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
   endfunction
   function automatic obs_t e_exec(logic is_r, logic [2:0] alu);
      return mk(0, 0, 0, 0, 0, 0, 2'b10, is_r ? 2'b00 : 2'b01, 2'b00, 2'b00, alu, 0);
   endfunction
   function automatic obs_t e_aluwb();
      return mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
   endfunction
   function automatic obs_t e_beq(logic z);
      return mk(0, 0, 0, 0, z, 0, 2'b10, 2'b00, 2'b00, 2'b00, 3'b001, 0);
   endfunction
   function automatic obs_t e_jal();
      return mk(0, 0, 0, 0, 1, 1, 2'b01, 2'b10, 2'b00, 2'b00, 3'b000, 0);
   endfunction
   function automatic obs_t e_fault();
      return mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1);
   endfunction

   function automatic step_t st(logic rdy, logic z, obs_t e);
      step_t s;
      s.rdy = rdy;
      s.z   = z;
      s.e   = e;
      return s;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      mem_ready = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      obs_t ex;
      rst = 1'b1;
      mem_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      sb_q.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
      ex = sb_q.pop_front();
      tests_run++;
      if ({mem_req, fault} !== {ex.req, ex.flt}) begin
         tests_failed++;
         $display("FAIL reset_held: got req/fault=%b%b, required %b%b", mem_req, fault, ex.req, ex.flt);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sb_q.push_back(e_fetch(0));
         @(negedge clk);
         ex = sb_q.pop_front();
         tests_run++;
         if (obs !== ex) begin
            tests_failed++;
            $display("FAIL reset_fetch cyc%0d: got %h, required %h", i, obs, ex);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_add();
      step_t s[$];
      obs_t  ex;
      do_reset();
      op = 7'b0110011; func3 = 3'b000; func7_5 = 1'b0;
      s = '{st(1, 0, e_fetch(1)), st(0, 0, e_decode()), st(0, 0, e_exec(1, 3'b000)),
            st(0, 0, e_aluwb()), st(0, 0, e_fetch(0))};
      for (int i = 0; i < s.size(); i++) begin
         mem_ready = s[i].rdy; zero = s[i].z;
         sb_q.push_back(s[i].e);
         @(negedge clk);
         ex = sb_q.pop_front();
         tests_run++;
         if (obs !== ex) begin
            tests_failed++;
            $display("FAIL add cyc%0d: got %h, required %h", i, obs, ex);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_alu_decode();
      logic [6:0] t_op[10] = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011,
                               7'b0110011, 7'b0010011, 7'b0010011, 7'b0010011, 7'b0010011};
      logic [2:0] t_f3[10] = '{3'b000, 3'b000, 3'b010, 3'b110, 3'b111,
                               3'b100, 3'b000, 3'b010, 3'b111, 3'b110};
      logic       t_f7[10] = '{0, 1, 1, 0, 0, 0, 1, 0, 0, 1};
      logic [2:0] t_alu[10] = '{3'b000, 3'b001, 3'b101, 3'b011, 3'b010,
                                3'b000, 3'b000, 3'b101, 3'b010, 3'b011};
      obs_t ex;
      do_reset();
      for (int k = 0; k < 10; k++) begin
         step_t s[$];
         op = t_op[k]; func3 = t_f3[k]; func7_5 = t_f7[k];
         s = '{st(1, 0, e_fetch(1)), st(0, 0, e_decode()),
               st(0, 0, e_exec(t_op[k] == 7'b0110011, t_alu[k])), st(0, 0, e_aluwb())};
         for (int i = 0; i < s.size(); i++) begin
            mem_ready = s[i].rdy; zero = s[i].z;
            sb_q.push_back(s[i].e);
            @(negedge clk);
            ex = sb_q.pop_front();
            tests_run++;
            if (obs !== ex) begin
               tests_failed++;
               $display("FAIL alu_dec entry%0d cyc%0d: got %h, required %h", k, i, obs, ex);
            end
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic test_lw_wait();
      step_t s[$];
      obs_t  ex;
      do_reset();
      op = 7'b0000011; func3 = 3'b010;
      s = '{st(1, 0, e_fetch(1)), st(0, 0, e_decode()), st(0, 0, e_memadr(0)),
            st(0, 0, e_memrd()), st(0, 0, e_memrd()), st(0, 0, e_memrd()), st(1, 0, e_memrd()),
            st(0, 0, e_memwb()), st(0, 0, e_fetch(0))};
      for (int i = 0; i < s.size(); i++) begin
         mem_ready = s[i].rdy; zero = s[i].z;
         sb_q.push_back(s[i].e);
         @(negedge clk);
         ex = sb_q.pop_front();
         tests_run++;
         if (obs !== ex) begin
            tests_failed++;
            $display("FAIL lw_wait cyc%0d: got %h, required %h", i, obs, ex);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_sw_jal();
      step_t s[$];
      obs_t  ex;
      do_reset();
      op = 7'b0100011;
      s = '{st(1, 0, e_fetch(1)), st(0, 0, e_decode()), st(0, 0, e_memadr(1)),
            st(0, 0, e_memwr()), st(1, 0, e_memwr()), st(1, 0, e_fetch(1))};
      for (int i = 0; i < s.size(); i++) begin
         mem_ready = s[i].rdy; zero = s[i].z;
         if (i == 5) op = 7'b1101111;
         sb_q.push_back(s[i].e);
         @(negedge clk);
         ex = sb_q.pop_front();
         tests_run++;
         if (obs !== ex) begin
            tests_failed++;
            $display("FAIL sw cyc%0d: got %h, required %h", i, obs, ex);
         end
         @(posedge clk);
         #1;
      end
      s = '{st(0, 0, e_decode()), st(0, 0, e_jal()), st(0, 0, e_fetch(0))};
      for (int i = 0; i < s.size(); i++) begin
         mem_ready = s[i].rdy; zero = s[i].z;
         sb_q.push_back(s[i].e);
         @(negedge clk);
         ex = sb_q.pop_front();
         tests_run++;
         if (obs !== ex) begin
            tests_failed++;
            $display("FAIL jal cyc%0d: got %h, required %h", i, obs, ex);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_beq();
      obs_t ex;
      do_reset();
      op = 7'b1100011; func3 = 3'b000;
      for (int k = 0; k < 2; k++) begin
         step_t s[$];
         logic  z;
         z = (k == 0);
         s = '{st(1, z, e_fetch(1)), st(0, z, e_decode()), st(0, z, e_beq(z)),
               st(0, z, e_fetch(0))};
         for (int i = 0; i < s.size(); i++) begin
            mem_ready = s[i].rdy; zero = s[i].z;
            sb_q.push_back(s[i].e);
            @(negedge clk);
            ex = sb_q.pop_front();
            tests_run++;
            if (obs !== ex) begin
               tests_failed++;
               $display("FAIL beq zero=%0b cyc%0d: got %h, required %h", z, i, obs, ex);
            end
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic test_illegal();
      obs_t ex;
      do_reset();
      op = 7'b0000000;
      for (int i = 0; i < 22; i++) begin
         mem_ready = (i < 2);
         sb_q.push_back(i == 0 ? e_fetch(1) : (i == 1 ? e_decode() : e_fault()));
         @(negedge clk);
         ex = sb_q.pop_front();
         tests_run++;
         if (obs !== ex) begin
            tests_failed++;
            $display("FAIL illegal cyc%0d: got %h, required %h", i, obs, ex);
         end
         @(posedge clk);
         #1;
      end
      do_reset();
      sb_q.push_back(e_fetch(0));
      @(negedge clk);
      ex = sb_q.pop_front();
      tests_run++;
      if (obs !== ex) begin
         tests_failed++;
         $display("FAIL illegal_rst_clear: got %h, required %h", obs, ex);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_timeout();
      obs_t ex;
      op = 7'b0110011;
      for (int k = 0; k < 2; k++) begin
         do_reset();
         for (int i = 0; i < 16; i++) begin
            // k=0: 15 idle cycles then fault; k=1: ready arrives on cycle 15
            mem_ready = (k == 1 && i == 14);
            if (i < 14)       ex = e_fetch(0);
            else if (i == 14) ex = e_fetch(k == 1);
            else              ex = (k == 1) ? e_decode() : e_fault();
            sb_q.push_back(ex);
            @(negedge clk);
            ex = sb_q.pop_front();
            tests_run++;
            if (obs !== ex) begin
               tests_failed++;
               $display("FAIL timeout run%0d cyc%0d: got %h, required %h", k, i, obs, ex);
            end
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic test_reset_midreq();
      step_t s[$];
      obs_t  ex;
      do_reset();
      op = 7'b0000011;
      s = '{st(1, 0, e_fetch(1)), st(0, 0, e_decode()), st(0, 0, e_memadr(0)),
            st(0, 0, e_memrd())};
      for (int i = 0; i < s.size(); i++) begin
         mem_ready = s[i].rdy; zero = s[i].z;
         sb_q.push_back(s[i].e);
         @(negedge clk);
         ex = sb_q.pop_front();
         tests_run++;
         if (obs !== ex) begin
            tests_failed++;
            $display("FAIL midreq cyc%0d: got %h, required %h", i, obs, ex);
         end
         if (i < s.size() - 1) begin
            @(posedge clk);
            #1;
         end
      end
      #1 rst = 1'b1;
      #1;
      tests_run++;
      if (mem_req !== 1'b0) begin
         tests_failed++;
         $display("FAIL midreq_drop: got mem_req=%b, required 0", mem_req);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      sb_q.push_back(e_fetch(0));
      @(negedge clk);
      ex = sb_q.pop_front();
      tests_run++;
      if (obs !== ex) begin
         tests_failed++;
         $display("FAIL midreq_refetch: got %h, required %h", obs, ex);
      end
      @(posedge clk);
      #1;
   endtask

`ifdef RISCV_MC_PERF_EN
   task automatic test_back_to_back();
      obs_t ex;
      do_reset();
      op = 7'b0110011; func3 = 3'b000; func7_5 = 1'b0;
      for (int i = 0; i < 13; i++) begin
         mem_ready = (i % 4 == 0) && (i < 12);
         case (i % 4)
            0:       ex = e_fetch(i < 12);
            1:       ex = e_decode();
            2:       ex = e_exec(1, 3'b000);
            default: ex = e_aluwb();
         endcase
         sb_q.push_back(ex);
         @(negedge clk);
         ex = sb_q.pop_front();
         tests_run++;
         if (obs !== ex) begin
            tests_failed++;
            $display("FAIL b2b cyc%0d: got %h, required %h", i, obs, ex);
         end
         if (i == 12) begin
            tests_run++;
            if (instret_cnt !== 32'd3) begin
               tests_failed++;
               $display("FAIL instret_cnt: got %0d, required 3", instret_cnt);
            end
            tests_run++;
            if (cycle_cnt !== 32'd12) begin
               tests_failed++;
               $display("FAIL cycle_cnt: got %0d, required 12", cycle_cnt);
            end
         end
         @(posedge clk);
         #1;
      end
   endtask
`endif

   initial begin
      test_reset();
      test_add();
      test_alu_decode();
      test_lw_wait();
      test_sw_jal();
      test_beq();
      test_illegal();
      test_timeout();
      test_reset_midreq();
`ifdef RISCV_MC_PERF_EN
      test_back_to_back();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
